key_gen_controller: RTL
=======================

Name: key_gen_controller

Overview:
- Sequences the LFSR key generator datapath for one transmitter session.
- Seeds it from the hard-coded key and runs a warm-up phase.
- Serves key/auth-tag requests from the MAC engine through valid/ready handshakes.
- Forces a re-seed after a fixed number of delivered messages.
- Sits between the key generator and the message-authentication datapath.

Parameters:
- KEY_WIDTH, 256: width of the seed and of the generated key.
- AUTH_TAG_WIDTH, 8: width of the generated authentication tag.
- WARMUP_CYCLES, 64: LFSR step cycles between seed load and the first key; 0 is legal; max 2^CNT_WIDTH-1.
- REKEY_INTERVAL, 16: messages delivered before a forced re-seed; must be at least 1.
- CNT_WIDTH, 8: width of the warm-up and message counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetN  in  1  reset, asynchronous and active-low.
- HC_key  in  KEY_WIDTH  hard-coded seed; sampled in LOAD.
- start  in  1  begins a session; honoured only in IDLE.
- stop  in  1  aborts the session from any state.
- kg_load  out  1  one-cycle seed-load strobe to the key generator.
- kg_seed  out  KEY_WIDTH  seed value; valid while kg_load=1.
- kg_step  out  1  advance the LFSR by one step this cycle.
- kg_key  in  KEY_WIDTH  current key generator state.
- kg_tag  in  AUTH_TAG_WIDTH  current auth-tag bits from the key generator.
- req_valid  in  1  requester wants a key/tag.
- req_ready  out  1  controller can accept a request.
- out_valid  out  1  out_key and out_tag are valid.
- out_ready  in  1  consumer accepts the delivered key/tag.
- out_key  out  KEY_WIDTH  delivered key.
- out_tag  out  AUTH_TAG_WIDTH  delivered tag.
- session_active  out  1  high in every state except IDLE.
- rekey_pulse  out  1  one-cycle pulse when a forced re-seed begins.

Behaviour:
- Reset (resetN=0, asynchronous): state=IDLE; all outputs 0, including out_key and out_tag; warm-up counter and msg_count = 0.
- FSM states: IDLE, LOAD, WARMUP, READY, DELIVER.
- IDLE:
  - All strobes 0.
  - start=1 -> LOAD.
- LOAD (exactly 1 cycle):
  - kg_load=1 and kg_seed=HC_key.
  - Warm-up counter loaded with WARMUP_CYCLES.
  - Next state is WARMUP, or READY if WARMUP_CYCLES=0.
- WARMUP:
  - kg_step=1 every cycle; counter decrements.
  - Leaves after exactly WARMUP_CYCLES step cycles, going to READY.
- READY:
  - req_ready=1.
  - On req_valid=1 at an edge:
    - Register kg_key into out_key and kg_tag into out_tag.
    - Drive kg_step=1 in that same cycle so the next key is fresh.
    - msg_count increments.
    - Next state DELIVER.
- DELIVER:
  - out_valid=1; req_ready=0.
  - out_key and out_tag stay stable until out_valid and out_ready are both high at an edge.
  - On that handshake: out_valid drops next cycle.
  - If msg_count==REKEY_INTERVAL: msg_count is cleared, rekey_pulse=1 for one cycle, next state LOAD (re-seeds from the current HC_key).
  - Otherwise next state READY.
- Latency:
  - start sampled at edge t: kg_load high in cycle t+1; READY reached at t+2+WARMUP_CYCLES.
  - Request accepted at edge c: out_valid high from c+1.
  - out_ready may be held high in advance; minimum delivery is 1 cycle in DELIVER.
- kg_step is never asserted in IDLE, LOAD or DELIVER.
- kg_load and kg_step are never asserted together.
- stop (synchronous abort):
  - Next state IDLE from any state; out_valid cleared; counters cleared; no rekey_pulse.
  - stop and start together in IDLE: stop wins, remain IDLE.
  - stop in the same cycle as a DELIVER handshake: the transfer completes (consumer has sampled it), then IDLE.
- start outside IDLE is ignored.
- req_valid outside READY is not acknowledged and has no effect.
- Asynchronous reset mid-session (any state) returns to the reset values immediately.
- Counter widths: the WARMUP_CYCLES and REKEY_INTERVAL limits in Parameters are required by design; out-of-range values are an illegal configuration.

Test Plan:
- Reset then start, with WARMUP_CYCLES=4 -> kg_load=1 for 1 cycle with kg_seed=HC_key, then kg_step=1 for exactly 4 cycles, then req_ready=1.
- In READY, req_valid=1 while kg_key=K0 and kg_tag=8'hA5, out_ready=0 for 3 cycles -> out_valid=1, out_key=K0 and out_tag=8'hA5 held stable; kg_step pulsed once at acceptance; req_ready=0 until the handshake completes.
- REKEY_INTERVAL=2, two back-to-back requests with out_ready=1 -> after the 2nd handshake: rekey_pulse=1 for one cycle, kg_load=1 the following cycle, the warm-up repeats, msg_count=0.
- WARMUP_CYCLES=0 -> LOAD goes directly to READY; no kg_step before the first request.
- stop asserted mid-WARMUP -> IDLE next cycle, kg_step=0, session_active=0; stop and start asserted together in IDLE -> stays IDLE.
- resetN pulled low during DELIVER -> out_valid, out_key and out_tag = 0 immediately; a subsequent start re-runs LOAD.

Source files
------------

// File: rtl/key_gen_controller.sv
// rtl/key_gen_controller.sv - Session sequencer for the LFSR key generator: seed, warm-up, key/tag delivery, forced re-seed.
module key_gen_controller #(
  parameter int KEY_WIDTH      = 256,
  parameter int AUTH_TAG_WIDTH = 8,
  parameter int WARMUP_CYCLES  = 64,
  parameter int REKEY_INTERVAL = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [KEY_WIDTH-1:0]      HC_key,
  input  logic                      start,
  input  logic                      stop,
  output logic                      kg_load,
  output logic [KEY_WIDTH-1:0]      kg_seed,
  output logic                      kg_step,
  input  logic [KEY_WIDTH-1:0]      kg_key,
  input  logic [AUTH_TAG_WIDTH-1:0] kg_tag,
  input  logic                      req_valid,
  output logic                      req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [KEY_WIDTH-1:0]      out_key,
  output logic [AUTH_TAG_WIDTH-1:0] out_tag,
  output logic                      session_active,
  output logic                      rekey_pulse
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_WARMUP  = 3'd2;
  localparam logic [2:0] S_READY   = 3'd3;
  localparam logic [2:0] S_DELIVER = 3'd4;

  localparam logic [CNT_WIDTH-1:0] WARMUP_LOAD = CNT_WIDTH'(WARMUP_CYCLES);
  localparam logic [CNT_WIDTH-1:0] REKEY_LIMIT = CNT_WIDTH'(REKEY_INTERVAL);

  logic [2:0]                r_state;
  logic [2:0]                w_next;
  logic [CNT_WIDTH-1:0]      r_warm_cnt;
  logic [CNT_WIDTH-1:0]      r_msg_cnt;
  logic [KEY_WIDTH-1:0]      r_out_key;
  logic [AUTH_TAG_WIDTH-1:0] r_out_tag;
  logic                      w_accept;
  logic                      w_handshake;
  logic                      w_last_msg;

  // A request that coincides with stop is dropped; the session is being torn down.
  assign w_accept    = (r_state == S_READY) && req_valid && !stop;
  assign w_handshake = (r_state == S_DELIVER) && out_ready;
  assign w_last_msg  = (r_msg_cnt == REKEY_LIMIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_LOAD;
      S_LOAD:    w_next = (WARMUP_CYCLES == 0) ? S_READY : S_WARMUP;
      S_WARMUP:  if (r_warm_cnt <= CNT_WIDTH'(1)) w_next = S_READY;
      S_READY:   if (req_valid) w_next = S_DELIVER;
      S_DELIVER: if (out_ready) w_next = w_last_msg ? S_LOAD : S_READY;
      default:   w_next = S_IDLE;
    endcase
    if (stop) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_warm_cnt <= '0;
      r_msg_cnt  <= '0;
      r_out_key  <= '0;
      r_out_tag  <= '0;
    end else begin
      r_state <= w_next;
      if (stop) begin
        r_warm_cnt <= '0;
        r_msg_cnt  <= '0;
      end else begin
        if (r_state == S_LOAD)
          r_warm_cnt <= WARMUP_LOAD;
        else if ((r_state == S_WARMUP) && (r_warm_cnt != '0))
          r_warm_cnt <= r_warm_cnt - 1'b1;
        if (w_accept)
          r_msg_cnt <= r_msg_cnt + 1'b1;
        else if (w_handshake && w_last_msg)
          r_msg_cnt <= '0;
      end
      if (w_accept) begin
        r_out_key <= kg_key;
        r_out_tag <= kg_tag;
      end
    end
  end

  assign kg_load        = (r_state == S_LOAD);
  assign kg_seed        = kg_load ? HC_key : '0;
  // The accepting cycle also steps the LFSR so the next request sees a fresh key.
  assign kg_step        = (r_state == S_WARMUP) || w_accept;
  assign req_ready      = (r_state == S_READY) && !stop;
  assign out_valid      = (r_state == S_DELIVER);
  assign out_key        = r_out_key;
  assign out_tag        = r_out_tag;
  assign session_active = (r_state != S_IDLE);
  assign rekey_pulse    = w_handshake && w_last_msg && !stop;

endmodule
